// File: rtl/glip_cypressfx3_slfifo_responder.sv
// glip_cypressfx3_slfifo_responder
//   Device-side stand-in for the Cypress FX3 synchronous slave-FIFO bus.
//   EPOUT (fx3_a=2'b11) is filled from the host_in stream and read by the
//   bus master through a 2-stage read pipe. EPIN (fx3_a=2'b00) is written
//   by the bus master and drained FWFT-style on the host_out stream.
//   Optional build macro: GLIP_FX3_RESPONDER_STATS_EN adds the stat_* counters.
module glip_cypressfx3_slfifo_responder #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 64,
  parameter int FLAG_WATERMARK = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fx3_dq_in,
  output logic [WIDTH-1:0] fx3_dq_out,
  output logic             fx3_dq_oe,
  input  logic             fx3_slcs_n,
  input  logic             fx3_sloe_n,
  input  logic             fx3_slrd_n,
  input  logic             fx3_slwr_n,
  input  logic             fx3_pktend_n,
  input  logic [1:0]       fx3_a,
  output logic             fx3_flaga,
  output logic             fx3_flagb,
  output logic             fx3_flagc,
  output logic             fx3_flagd,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  input  logic [WIDTH-1:0] host_in_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_last,
  output logic             host_zlp,
  output logic             err_overflow,
  output logic             err_underflow
`ifdef GLIP_FX3_RESPONDER_STATS_EN
  ,
  output logic [31:0]      stat_wr_words,
  output logic [31:0]      stat_rd_words,
  output logic [15:0]      stat_pkts
`endif
);

  localparam int           AW        = $clog2(DEPTH);
  localparam logic [AW:0]  DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]  WMARK_CNT = (AW+1)'(FLAG_WATERMARK);
  localparam logic [AW:0]  CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [1:0]   EP_IN     = 2'b00;
  localparam logic [1:0]   EP_OUT    = 2'b11;

  // EPOUT buffer (host -> bus master)
  logic [WIDTH-1:0] out_mem [DEPTH];
  logic [AW-1:0]    out_wr_ptr;
  logic [AW-1:0]    out_rd_ptr;
  logic [AW:0]      out_cnt;
  logic [AW:0]      out_cnt_nxt;

  // EPIN buffer (bus master -> host); last bits live in flops so they can be
  // marked after the word was written
  logic [WIDTH-1:0] in_mem [DEPTH];
  logic [DEPTH-1:0] in_last;
  logic [AW-1:0]    in_wr_ptr;
  logic [AW-1:0]    in_rd_ptr;
  logic [AW-1:0]    in_newest;
  logic [AW:0]      in_cnt;
  logic [AW:0]      in_cnt_nxt;

  // read pipe between the EPOUT buffer and fx3_dq_out
  logic             rd_s1_vld;
  logic [WIDTH-1:0] rd_s1_data;
  logic             rd_s2_vld;
  logic [WIDTH-1:0] rd_s2_data;

  logic bus_sel;
  logic bus_rd;
  logic bus_wr;
  logic bus_pktend;
  logic out_push;
  logic out_pop;
  logic in_push;
  logic in_pop;
  logic pkt_mark;
  logic pkt_zlp;

  // strobe decode; a=01/10 never matches so those strobes fall through
  assign bus_sel    = !fx3_slcs_n;
  assign bus_rd     = bus_sel && !fx3_slrd_n && (fx3_a == EP_OUT);
  assign bus_wr     = bus_sel && !fx3_slwr_n && (fx3_a == EP_IN);
  assign bus_pktend = bus_sel && fx3_slwr_n && !fx3_pktend_n && (fx3_a == EP_IN);

  // all fullness/emptiness decisions use the pre-update counts, so a pop of
  // an empty buffer can never be satisfied by a push in the same cycle
  assign host_in_ready  = (out_cnt < DEPTH_CNT);
  assign out_push       = host_in_valid && host_in_ready;
  assign out_pop        = bus_rd && (out_cnt != '0);

  assign host_out_valid = (in_cnt != '0);
  assign in_pop         = host_out_valid && host_out_ready;
  assign in_push        = bus_wr && (in_cnt < DEPTH_CNT);

  assign in_newest      = in_wr_ptr - PTR_ONE;
  assign pkt_mark       = bus_pktend && (in_cnt != '0) && !in_last[in_newest];
  assign pkt_zlp        = bus_pktend && !pkt_mark;

  // FWFT head; a mark aimed at the head word while it leaves must still be seen
  assign host_out_data  = in_mem[in_rd_ptr];
  assign host_out_last  = in_last[in_rd_ptr] || (pkt_mark && in_pop && (in_cnt == CNT_ONE));

  // output enable follows the strobes directly, but never while held in reset
  assign fx3_dq_oe      = rst_n && !fx3_slcs_n && !fx3_sloe_n;

  // post-update occupancy for both buffers
  always_comb begin
    out_cnt_nxt = out_cnt;
    if (out_push && !out_pop)
      out_cnt_nxt = out_cnt + CNT_ONE;
    else if (!out_push && out_pop)
      out_cnt_nxt = out_cnt - CNT_ONE;

    in_cnt_nxt = in_cnt;
    if (in_push && !in_pop)
      in_cnt_nxt = in_cnt + CNT_ONE;
    else if (!in_push && in_pop)
      in_cnt_nxt = in_cnt - CNT_ONE;
  end

  // buffer storage, no reset needed: contents are only visible through counts
  always_ff @(posedge clk) begin
    if (out_push)
      out_mem[out_wr_ptr] <= host_in_data;
    if (in_push)
      in_mem[in_wr_ptr] <= fx3_dq_in;
  end

  // EPOUT pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_cnt    <= '0;
    end else begin
      if (out_push)
        out_wr_ptr <= out_wr_ptr + PTR_ONE;
      if (out_pop)
        out_rd_ptr <= out_rd_ptr + PTR_ONE;
      out_cnt <= out_cnt_nxt;
    end
  end

  // EPIN pointers, count and packet-end bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_cnt    <= '0;
      in_last   <= '0;
    end else begin
      if (in_push) begin
        in_wr_ptr          <= in_wr_ptr + PTR_ONE;
        in_last[in_wr_ptr] <= !fx3_pktend_n;
      end
      if (pkt_mark)
        in_last[in_newest] <= 1'b1;
      if (in_pop)
        in_rd_ptr <= in_rd_ptr + PTR_ONE;
      in_cnt <= in_cnt_nxt;
    end
  end

  // read pipe: popped word reaches fx3_dq_out two edges after the pop edge;
  // stages only advance on valid so the bus keeps the last word otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s1_vld  <= 1'b0;
      rd_s1_data <= '0;
      rd_s2_vld  <= 1'b0;
      rd_s2_data <= '0;
      fx3_dq_out <= '0;
    end else begin
      rd_s1_vld <= out_pop;
      if (out_pop)
        rd_s1_data <= out_mem[out_rd_ptr];
      rd_s2_vld <= rd_s1_vld;
      if (rd_s1_vld)
        rd_s2_data <= rd_s1_data;
      if (rd_s2_vld)
        fx3_dq_out <= rd_s2_data;
    end
  end

  // flags from post-update counts, ZLP pulse and sticky error bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fx3_flaga     <= 1'b1;
      fx3_flagb     <= 1'b1;
      fx3_flagc     <= 1'b0;
      fx3_flagd     <= 1'b0;
      host_zlp      <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      fx3_flaga <= (in_cnt_nxt < DEPTH_CNT);
      fx3_flagb <= ((DEPTH_CNT - in_cnt_nxt) > WMARK_CNT);
      fx3_flagc <= (out_cnt_nxt != '0);
      fx3_flagd <= (out_cnt_nxt > WMARK_CNT);
      host_zlp  <= pkt_zlp;
      if (bus_wr && !in_push)
        err_overflow <= 1'b1;
      if (bus_rd && !out_pop)
        err_underflow <= 1'b1;
    end
  end

`ifdef GLIP_FX3_RESPONDER_STATS_EN
  // traffic counters; free-running with natural wrap-around
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_words <= '0;
      stat_rd_words <= '0;
      stat_pkts     <= '0;
    end else begin
      stat_wr_words <= stat_wr_words + 32'(in_push);
      stat_rd_words <= stat_rd_words + 32'(out_pop);
      stat_pkts     <= stat_pkts + 16'(in_push && !fx3_pktend_n)
                                 + 16'(pkt_mark) + 16'(pkt_zlp);
    end
  end
`endif

endmodule
